// File: rtl/br_pkg.sv
// Shared definitions for the branch resolution path: funct3 branch encodings,
// the flush/squash state enum and the sequential PC increment.
package br_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int PC_INC = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SQUASH = 2'd2
  } br_state_e;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition evaluation: jump always takes, conditional
// branches compare rs1/rs2 per funct3, reserved encodings never take.
module br_cond_eval
  import br_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            jump,
  input  logic            branch,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            take
);

  always_comb begin
    take = 1'b0;
    if (jump) begin
      take = 1'b1;
    end else if (branch) begin
      case (funct3)
        F3_BEQ:  take = (rs1 == rs2);
        F3_BNE:  take = (rs1 != rs2);
        F3_BLT:  take = ($signed(rs1) <  $signed(rs2));
        F3_BGE:  take = ($signed(rs1) >= $signed(rs2));
        F3_BLTU: take = (rs1 <  rs2);
        F3_BGEU: take = (rs1 >= rs2);
        default: take = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX/MEM branch resolution: registered outcome/target/mispredict plus a
// flush -> squash sequence to the front end. BR_STATS_EN adds saturating counters.
module branch_resolve_unit
  import br_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int PC_W          = 32,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic            branch,
  input  logic            jump,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] imm,
  input  logic            pred_taken,
  input  logic            stall,
  output logic            valid_out,
  output logic            take_branch,
  output logic [PC_W-1:0] target_pc,
  output logic            mispredict,
  output logic            flush
`ifdef BR_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYCLES);

  br_state_e       state, state_next;
  logic [3:0]      cnt, cnt_next;
  logic            take_c, mis_c, accept;
  logic [PC_W-1:0] target_c;

  br_cond_eval #(.XLEN(XLEN)) u_cond (
    .jump   (jump),
    .branch (branch),
    .funct3 (funct3),
    .rs1    (rs1_data),
    .rs2    (rs2_data),
    .take   (take_c)
  );

  // Only IDLE accepts work; anything arriving in FLUSH/SQUASH is wrong-path.
  assign accept   = valid_in && !stall && (state == ST_IDLE);
  assign mis_c    = (branch || jump) && (take_c != pred_taken);
  assign target_c = take_c ? (pc + imm) : (pc + PC_W'(PC_INC));

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    flush      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && mis_c) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (!stall) begin
          cnt_next   = SQ_LOAD;
          state_next = ST_SQUASH;
        end
      end
      ST_SQUASH: begin
        if (!stall) begin
          cnt_next = cnt - 4'd1;
          if (cnt <= 4'd1) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      valid_out   <= 1'b0;
      take_branch <= 1'b0;
      target_pc   <= '0;
      mispredict  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (!stall) begin
        valid_out   <= accept;
        take_branch <= accept && take_c;
        mispredict  <= accept && mis_c;
        if (accept) target_pc <= target_c;
      end
    end
  end

`ifdef BR_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else if (accept) begin
      if ((branch || jump) && (stat_branches != 32'hFFFF_FFFF))
        stat_branches <= stat_branches + 32'd1;
      if (mis_c && (stat_mispredicts != 32'hFFFF_FFFF))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: the driver pushes reference results
// computed from the branch rules; a negedge monitor pops and compares.
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  localparam int PC_W = 32;
  localparam int SQ   = 2;
  localparam int W    = 2 + PC_W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid_in, branch, jump, pred_taken, stall;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [PC_W-1:0] pc, imm;
  logic            valid_out, take_branch, mispredict, flush;
  logic [PC_W-1:0] target_pc;
`ifdef BR_STATS_EN
  logic [31:0]     stat_branches, stat_mispredicts;
`endif

  int tests = 0;
  int fails = 0;
  int blocked = 0;
  int n_br = 0;
  int n_mis = 0;
  bit prev_stall = 1'b0;
  logic [W-1:0] exp_q[$];
  bit           flush_q[$];

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .PC_W(PC_W), .SQUASH_CYCLES(SQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .branch     (branch),
    .jump       (jump),
    .funct3     (funct3),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .pc         (pc),
    .imm        (imm),
    .pred_taken (pred_taken),
    .stall      (stall),
    .valid_out  (valid_out),
    .take_branch(take_branch),
    .target_pc  (target_pc),
    .mispredict (mispredict),
    .flush      (flush)
`ifdef BR_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic ref_take(input logic br, input logic jp, input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (jp) return 1'b1;
    if (!br) return 1'b0;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // One clock of stimulus; the expected result is queued at the edge that consumes it.
  task automatic cycle(input logic v, input logic br, input logic jp, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                       input logic [31:0] im, input logic pr, input logic st);
    logic t, m;
    logic [31:0] tgt;
    bit acc;
    valid_in = v; branch = br; jump = jp; funct3 = f3;
    rs1_data = a; rs2_data = b; pc = p; imm = im; pred_taken = pr; stall = st;
    acc = 1'b0;
    if (!st) begin
      if (blocked > 0) blocked--;
      else if (v) acc = 1'b1;
    end
    t   = ref_take(br, jp, f3, a, b);
    tgt = t ? p + im : p + 32'd4;
    m   = (br || jp) && (t != pr);
    @(posedge clk);
    if (acc) begin
      exp_q.push_back({t, m, tgt});
      if (br || jp) n_br++;
      if (m) begin
        flush_q.push_back(1'b1);
        blocked = 1 + SQ;
        n_mis++;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid_out"}, 64'(valid_out), 64'd0);
    chk({tag, "_take"}, 64'(take_branch), 64'd0);
    chk({tag, "_target"}, 64'(target_pc), 64'd0);
    chk({tag, "_mispredict"}, 64'(mispredict), 64'd0);
    chk({tag, "_flush"}, 64'(flush), 64'd0);
  endtask

  task automatic apply_reset_mid();
    valid_in = 1'b0;
    stall = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_zero("async_reset");
    exp_q.delete();
    flush_q.delete();
    blocked = 0;
    n_br = 0;
    n_mis = 0;
    #1 rst_n = 1'b1;
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (valid_out && !prev_stall) begin
          if (exp_q.size() == 0) chk("unexpected_valid_out", 64'(valid_out), 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("result", 64'({take_branch, mispredict, target_pc}), 64'(e));
          end
        end
        if (!prev_stall) chk("latency_pending", 64'(exp_q.size()), 64'd0);
        chk("flush_level", 64'(flush), 64'(flush_q.size() > 0));
        if (flush && !stall && flush_q.size() > 0) void'(flush_q.pop_front());
      end
      prev_stall = stall;
    end
  end

  initial begin : stim
    logic [31:0] a, b;
    logic [2:0]  f3;
    rst_n = 1'b0;
    valid_in = 0; branch = 0; jump = 0; funct3 = 0; rs1_data = 0; rs2_data = 0;
    pc = 0; imm = 0; pred_taken = 0; stall = 0;
    #3 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // BEQ taken, correctly predicted
    cycle(1, 1, 0, 3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1, 0);
    idle(2);
    // BLT vs BLTU with a negative rs1
    cycle(1, 1, 0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 1, 0);
    cycle(1, 1, 0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h40, 0, 0);
    idle(2);
    // BNE mispredict with valid_in held high through the squash
    cycle(1, 1, 0, 3'b001, 32'h1, 32'h2, 32'h400, 32'h10, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 3'b000, 32'h7, 32'h7, 32'h500 + 32'(i * 4), 32'h8, 1, 0);
    idle(2);
    // Mispredict, then a 3-cycle stall holding the pending flush
    cycle(1, 1, 0, 3'b101, 32'h3, 32'h9, 32'h600, 32'h30, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 3'b000, 0, 0, 32'h700, 32'h4, 1, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 32'h704, 0, 0, 1);
    idle(4);
    // Async reset in the middle of a squash
    cycle(1, 0, 1, 3'b000, 0, 0, 32'h800, 32'h100, 0, 0);
    idle(2);
    apply_reset_mid();
    cycle(1, 1, 0, 3'b111, 32'h9, 32'h3, 32'h900, 32'h24, 1, 0);
    idle(2);
    // JAL with target wraparound
    cycle(1, 0, 1, 3'b000, 0, 0, 32'hFFFF_FFF0, 32'h20, 1, 0);
    // Non-branch op passes valid through with take=0
    cycle(1, 0, 0, 3'b000, 0, 0, 32'hA00, 32'h8, 1, 0);
    cycle(1, 1, 0, 3'b010, 32'h1, 32'h1, 32'hB00, 32'h8, 0, 0);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 4)) : $urandom);
      f3 = 3'($urandom_range(0, 7));
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
            f3, a, b, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0));
    end
    idle(6);

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("flush_q_drained", 64'(flush_q.size()), 64'd0);
`ifdef BR_STATS_EN
    chk("stat_branches", 64'(stat_branches), 64'(n_br));
    chk("stat_mispredicts", 64'(stat_mispredicts), 64'(n_mis));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
